sr595_frame_receiver: RTL
=========================

Name: sr595_frame_receiver

Overview:
- Receive-side counterpart of the LED-matrix 74HC595 chain driver. Accepts the three-wire SER/SRCLK/RCLK stream plus the SRCLR line, and reconstructs the latched row and column words.
- Used for on-board loopback (ARDUINO_IO outputs jumpered back to inputs) and as a cycle-accurate model of the display chain in benches.
- All protocol lines are asynchronous to clk and are synchronised internally.

Parameters:
WIDTH, 16, bits per latched word (row and column each)
SYNC_STAGES, 2, flip-flop stages on every protocol input (minimum 2)
FILTER_LEN, 4, stable-cycle count required per edge; used only with the optional feature

Ports:
clk  in  1  system clock (50 MHz)
clr  in  1  synchronous active-high reset
ser_in  in  1  row serial data (SER)
ser_col_in  in  1  column serial data
srclk_in  in  1  shift clock; rising edge shifts
rclk_in  in  1  storage clock; rising edge latches
srclr_n_in  in  1  active-low shift-register clear (595 SRCLR)
row_q  out  WIDTH  last latched row word
col_q  out  WIDTH  last latched column word
frame_valid  out  1  one-cycle pulse per latch
bit_count_err  out  1  one-cycle pulse coincident with frame_valid when shifts since last latch != WIDTH
frame_cnt  out  16  latch counter, wraps 0xFFFF->0
busy  out  1  high while state != IDLE

Behaviour:
- Reset: clr=1 at a clk edge zeroes row_q, col_q, frame_cnt, shift registers, shift counter, synchroniser and edge history; frame_valid, bit_count_err, busy = 0; state = IDLE. clr overrides all other activity, including mid-frame.
- Sync: ser_in, ser_col_in, srclk_in, rclk_in and srclr_n_in pass through identical SYNC_STAGES chains, so data stays aligned with the clocks.
  - Edge detect compares the last sync stage with a one-cycle-delayed copy.
  - Data is taken from the last sync stage in the cycle the srclk rise is detected.
- Shift (srclk rise): sr_row <= {ser, sr_row[WIDTH-1:1]}; same for sr_col.
  - The first bit sent ends in bit 0 after WIDTH shifts.
  - Shift counter increments, saturating at 2*WIDTH.
- Latch (rclk rise): row_q <= sr_row, col_q <= sr_col; frame_valid=1 for one cycle; frame_cnt+1.
  - bit_count_err=1 in the same cycle if the counter != WIDTH.
  - The counter then restarts at 0. Shift registers are NOT cleared.
- Latency: if rclk_in is first sampled high at clk edge N, frame_valid is high in the cycle after edge N+SYNC_STAGES+1.
- Simultaneous srclk and rclk rise in one cycle (tied-clock 595 semantics):
  - latch takes the pre-shift contents;
  - the shift still occurs;
  - the counter restarts at 1.
- srclr_n low (synchronised):
  - sr_row, sr_col and the counter are held at 0 and srclk edges are ignored;
  - row_q, col_q and frame_cnt are unchanged;
  - an rclk rise during clear latches zeros and counts as a frame with count 0 (error).
- State machine, updated each cycle after shift/latch:
  - IDLE: counter == 0.
  - SHIFT: 0 < counter < WIDTH.
  - FULL: counter == WIDTH.
  - OVER: counter > WIDTH.
  - Transitions: IDLE->SHIFT on the first shift; SHIFT->FULL on the WIDTH-th shift; FULL->OVER on a further shift; any->IDLE on latch (or ->SHIFT on a simultaneous edge) or on clear.
- frame_cnt wraps silently. bit_count_err is not sticky.

Optional Feature:
SR595_RX_GLITCH_FILTER_EN
- Defined: srclk and rclk edges are accepted only after the synchronised level differs from the accepted level for FILTER_LEN consecutive cycles.
  - Pulses shorter than FILTER_LEN cycles are ignored.
  - Latency grows by FILTER_LEN-1 cycles.
  - Data is sampled with the same delay.
- Undefined: no filter; every synchronised edge is accepted. FILTER_LEN is unused.

Test Plan:
- 16 srclk pulses (each 50 cycles high/low) carrying row 0x5369 and col 0x0002, LSB first, then rclk pulse -> row_q=0x5369, col_q=0x0002, one frame_valid, bit_count_err=0, frame_cnt=1, busy back to 0.
- 15 shifts of row 0x5369 bits 0..14 from reset, then rclk -> row_q=0xA6D2, bit_count_err=1 with frame_valid.
- After frame 1, 8 shifts, srclr_n low 20 cycles, then 16 shifts of all-ones and rclk -> row_q unchanged until latch, then 0xFFFF; err=0; frame_cnt=2.
- 16 shifts of 0xFFFF, then srclk and rclk rising together with ser=0 -> row_q=0xFFFF, counter=1, state SHIFT, err=0.
- Assert clr after 10 shifts -> all outputs 0 next cycle; a subsequent full 16-bit frame latches correctly with frame_cnt=1.
- 2-cycle srclk glitch between valid shifts -> without the macro counted (err=1 at latch); with SR595_RX_GLITCH_FILTER_EN ignored (err=0).

Source files
------------

// File: rtl/sr595_frame_receiver.sv
// sr595_frame_receiver
// Receive-side model of a 74HC595 row/column chain. It rebuilds the latched
// row and column words from the SER / SRCLK / RCLK / SRCLR lines.
//
// Optional build macro: SR595_RX_GLITCH_FILTER_EN
//   When defined, srclk and rclk edges are accepted only once the
//   synchronised level has differed from the accepted level for FILTER_LEN
//   consecutive cycles. Shorter pulses are ignored.
//
// Ports:
//   clk           system clock
//   clr           synchronous active-high reset
//   ser_in        row serial data
//   ser_col_in    column serial data
//   srclk_in      shift clock (rising edge shifts)
//   rclk_in       storage clock (rising edge latches)
//   srclr_n_in    active-low shift-register clear
//   row_q         last latched row word
//   col_q         last latched column word
//   frame_valid   one-cycle pulse per latch
//   bit_count_err pulse with frame_valid when shifts since last latch != WIDTH
//   frame_cnt     latch counter, wraps
//   busy          high while the shift counter is non-zero
module sr595_frame_receiver #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             ser_in,
  input  logic             ser_col_in,
  input  logic             srclk_in,
  input  logic             rclk_in,
  input  logic             srclr_n_in,
  output logic [WIDTH-1:0] row_q,
  output logic [WIDTH-1:0] col_q,
  output logic             frame_valid,
  output logic             bit_count_err,
  output logic [15:0]      frame_cnt,
  output logic             busy
);

  localparam int CW = $clog2(2 * WIDTH + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;
  localparam logic [1:0] OVER  = 2'd3;

  // Bit order inside each synchroniser stage: {srclr_n, rclk, srclk, ser_col, ser}.
  // All lines share one chain so data stays aligned with the clocks.
  logic [4:0] sync_q [SYNC_STAGES];
  logic [4:0] sync_last;

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= {srclr_n_in, rclk_in, srclk_in, ser_col_in, ser_in};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign sync_last = sync_q[SYNC_STAGES-1];

  logic srclk_rise;
  logic rclk_rise;

`ifdef SR595_RX_GLITCH_FILTER_EN
  localparam int FW = $clog2(FILTER_LEN + 1);

  logic          srclk_acc;
  logic          rclk_acc;
  logic [FW-1:0] srclk_run;
  logic [FW-1:0] rclk_run;
  logic          srclk_accept;
  logic          rclk_accept;

  // An edge is taken in the cycle the level has been different for FILTER_LEN cycles.
  assign srclk_accept = (sync_last[2] != srclk_acc) && (srclk_run == FW'(FILTER_LEN - 1));
  assign rclk_accept  = (sync_last[3] != rclk_acc)  && (rclk_run  == FW'(FILTER_LEN - 1));
  assign srclk_rise   = srclk_accept & sync_last[2];
  assign rclk_rise    = rclk_accept  & sync_last[3];

  always_ff @(posedge clk) begin
    if (clr) begin
      srclk_acc <= 1'b0;
      rclk_acc  <= 1'b0;
      srclk_run <= '0;
      rclk_run  <= '0;
    end else begin
      if (sync_last[2] == srclk_acc) begin
        srclk_run <= '0;
      end else if (srclk_accept) begin
        srclk_acc <= sync_last[2];
        srclk_run <= '0;
      end else begin
        srclk_run <= srclk_run + FW'(1);
      end
      if (sync_last[3] == rclk_acc) begin
        rclk_run <= '0;
      end else if (rclk_accept) begin
        rclk_acc <= sync_last[3];
        rclk_run <= '0;
      end else begin
        rclk_run <= rclk_run + FW'(1);
      end
    end
  end
`else
  logic srclk_d;
  logic rclk_d;

  assign srclk_rise = sync_last[2] & ~srclk_d;
  assign rclk_rise  = sync_last[3] & ~rclk_d;

  always_ff @(posedge clk) begin
    if (clr) begin
      srclk_d <= 1'b0;
      rclk_d  <= 1'b0;
    end else begin
      srclk_d <= sync_last[2];
      rclk_d  <= sync_last[3];
    end
  end
`endif

  // Edge pulses and the data bits are registered together so the data
  // used for a shift is the value seen in the cycle the edge was detected.
  logic srclk_rise_q;
  logic rclk_rise_q;
  logic ser_q;
  logic ser_col_q;
  logic clear_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      srclk_rise_q <= 1'b0;
      rclk_rise_q  <= 1'b0;
      ser_q        <= 1'b0;
      ser_col_q    <= 1'b0;
      clear_q      <= 1'b0;
    end else begin
      srclk_rise_q <= srclk_rise;
      rclk_rise_q  <= rclk_rise;
      ser_q        <= sync_last[0];
      ser_col_q    <= sync_last[1];
      clear_q      <= ~sync_last[4];
    end
  end

  logic [WIDTH-1:0] sr_row;
  logic [WIDTH-1:0] sr_col;
  logic [CW-1:0]    shift_cnt;
  logic [CW-1:0]    cnt_next;
  logic [1:0]       state;
  logic [1:0]       state_next;
  logic             do_shift;

  // A latch restarts the count; a shift in the same cycle makes it 1.
  always_comb begin
    do_shift   = srclk_rise_q & ~clear_q;
    cnt_next   = shift_cnt;
    state_next = IDLE;
    if (clear_q) begin
      cnt_next = '0;
    end else if (rclk_rise_q) begin
      cnt_next = do_shift ? CW'(1) : '0;
    end else if (do_shift && shift_cnt != CW'(2 * WIDTH)) begin
      cnt_next = shift_cnt + CW'(1);
    end
    if (cnt_next == '0)                state_next = IDLE;
    else if (cnt_next < CW'(WIDTH))    state_next = SHIFT;
    else if (cnt_next == CW'(WIDTH))   state_next = FULL;
    else                               state_next = OVER;
  end

  // Latch uses the pre-shift register contents, so a tied srclk/rclk edge
  // behaves like a real 595. A latch during clear stores zeros.
  always_ff @(posedge clk) begin
    if (clr) begin
      sr_row        <= '0;
      sr_col        <= '0;
      shift_cnt     <= '0;
      state         <= IDLE;
      row_q         <= '0;
      col_q         <= '0;
      frame_valid   <= 1'b0;
      bit_count_err <= 1'b0;
      frame_cnt     <= '0;
    end else begin
      frame_valid   <= rclk_rise_q;
      bit_count_err <= rclk_rise_q && (clear_q || shift_cnt != CW'(WIDTH));
      if (rclk_rise_q) begin
        row_q     <= clear_q ? '0 : sr_row;
        col_q     <= clear_q ? '0 : sr_col;
        frame_cnt <= frame_cnt + 16'd1;
      end
      if (clear_q) begin
        sr_row <= '0;
        sr_col <= '0;
      end else if (do_shift) begin
        sr_row <= {ser_q, sr_row[WIDTH-1:1]};
        sr_col <= {ser_col_q, sr_col[WIDTH-1:1]};
      end
      shift_cnt <= cnt_next;
      state     <= state_next;
    end
  end

  assign busy = (state != IDLE);

endmodule
